// File: rtl/bsg_mem_hs_pkg.sv
// Shared request struct macro and constants for the handshake wrapper around a
// 1rw synchronous byte-masked memory.
`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) == 1) ? 1 : $clog2(x))
`endif

// The struct's field widths come from the instantiating module's parameters,
// so the typedef is declared in-place by macro rather than in the package.
`define BSG_MEM_HS_REQ_S(aw, dw, mw) \
  typedef struct packed { \
    logic          w; \
    logic [aw-1:0] addr; \
    logic [dw-1:0] data; \
    logic [mw-1:0] mask; \
  } bsg_mem_hs_req_s

package bsg_mem_hs_pkg;

  localparam int bsg_mem_hs_min_fifo_els = 2;

  function automatic int bsg_mem_hs_ptr_width(input int els);
    return (els <= 1) ? 1 : $clog2(els);
  endfunction

endpackage

// File: rtl/bsg_mem_hs_rdata_fifo.sv
// Circular read-data buffer: enqueue at tail, dequeue at head, simultaneous
// enq/deq allowed. Synchronous active-high reset clears pointers and count.
module bsg_mem_hs_rdata_fifo
  import bsg_mem_hs_pkg::*;
#(
  parameter int width_p = 32,
  parameter int els_p   = 2,
  localparam int ptr_width_lp = bsg_mem_hs_ptr_width(els_p),
  localparam int cnt_width_lp = $clog2(els_p + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    enq_i,
  input  logic [width_p-1:0]      data_i,
  input  logic                    deq_i,
  output logic [width_p-1:0]      data_o,
  output logic                    empty_o,
  output logic [cnt_width_lp-1:0] count_o
);

  logic [width_p-1:0]      mem_q [els_p];
  logic [width_p-1:0]      mem_d [els_p];
  logic [ptr_width_lp-1:0] wr_ptr_q, wr_ptr_d;
  logic [ptr_width_lp-1:0] rd_ptr_q, rd_ptr_d;
  logic [cnt_width_lp-1:0] count_q, count_d;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
    return (p == ptr_width_lp'(els_p - 1)) ? '0 : p + ptr_width_lp'(1);
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq_i) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (deq_i) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({enq_i, deq_i})
      2'b10:   count_d = count_q + cnt_width_lp'(1);
      2'b01:   count_d = count_q - cnt_width_lp'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/bsg_mem_1rw_sync_mask_write_byte_hs.sv
// Ready/valid front end and valid/yumi back end around a 1rw sync byte-masked
// memory. Define BSG_MEM_HS_RDATA_BYPASS_EN to present read data one cycle early.
module bsg_mem_1rw_sync_mask_write_byte_hs
  import bsg_mem_hs_pkg::*;
#(
  parameter int els_p        = 16,
  parameter int data_width_p = 32,
  parameter int fifo_els_p   = 2,
  localparam int addr_width_lp       = `BSG_SAFE_CLOG2(els_p),
  localparam int write_mask_width_lp = data_width_p >> 3
) (
  input  logic                           clk_i,
  input  logic                           reset_i,

  input  logic                           v_i,
  output logic                           ready_o,
  input  logic                           w_i,
  input  logic [addr_width_lp-1:0]       addr_i,
  input  logic [data_width_p-1:0]        data_i,
  input  logic [write_mask_width_lp-1:0] write_mask_i,

  output logic                           mem_v_o,
  output logic                           mem_w_o,
  output logic [addr_width_lp-1:0]       mem_addr_o,
  output logic [data_width_p-1:0]        mem_data_o,
  output logic [write_mask_width_lp-1:0] mem_write_mask_o,
  input  logic [data_width_p-1:0]        mem_data_i,

  output logic                           v_o,
  output logic [data_width_p-1:0]        data_o,
  input  logic                           yumi_i
);

  localparam int cnt_width_lp = $clog2(fifo_els_p + 1);

  if (data_width_p % 8 != 0) begin : g_bad_width
    $error("data_width_p must be a multiple of 8");
  end
  if (fifo_els_p < bsg_mem_hs_min_fifo_els) begin : g_bad_depth
    $error("fifo_els_p must be at least 2");
  end

  `BSG_MEM_HS_REQ_S(addr_width_lp, data_width_p, write_mask_width_lp);

  bsg_mem_hs_req_s           req;
  logic                      rd_pending_q, rd_pending_d;
  logic                      fifo_enq, fifo_deq, fifo_empty;
  logic [data_width_p-1:0]   fifo_data;
  logic [cnt_width_lp-1:0]   fifo_count;
  logic [cnt_width_lp:0]     credits_used;
  logic                      deq_now;

  assign req = '{w: w_i, addr: addr_i, data: data_i, mask: write_mask_i};

  assign mem_v_o          = v_i & ready_o;
  assign mem_w_o          = req.w;
  assign mem_addr_o       = req.addr;
  assign mem_data_o       = req.data;
  assign mem_write_mask_o = req.mask;

  // A word taken this cycle frees its slot immediately; this is what lets a
  // consumer holding yumi_i sustain one read per cycle with two buffer entries.
  assign deq_now      = yumi_i & v_o;
  assign credits_used = {1'b0, fifo_count}
                      + (cnt_width_lp+1)'(rd_pending_q)
                      - (cnt_width_lp+1)'(deq_now);
  assign ready_o      = ~reset_i & (credits_used < (cnt_width_lp+1)'(fifo_els_p));

  always_comb begin
    rd_pending_d = mem_v_o & ~w_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) rd_pending_q <= 1'b0;
    else         rd_pending_q <= rd_pending_d;
  end

`ifdef BSG_MEM_HS_RDATA_BYPASS_EN
  assign v_o      = ~reset_i & (rd_pending_q | ~fifo_empty);
  assign data_o   = fifo_empty ? mem_data_i : fifo_data;
  assign fifo_enq = rd_pending_q & ~(fifo_empty & yumi_i);
`else
  assign v_o      = ~reset_i & ~fifo_empty;
  assign data_o   = fifo_data;
  assign fifo_enq = rd_pending_q;
`endif
  assign fifo_deq = deq_now & ~fifo_empty;

  bsg_mem_hs_rdata_fifo #(
    .width_p(data_width_p),
    .els_p  (fifo_els_p)
  ) u_rdata_fifo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .enq_i  (fifo_enq),
    .data_i (mem_data_i),
    .deq_i  (fifo_deq),
    .data_o (fifo_data),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!yumi_i || v_o) else $error("yumi_i asserted while v_o is low");
    end
  end

endmodule
